// File: rtl/fb_scanner.sv
// fb_scanner: scans a frame buffer as upper/lower panel halves and pushes
// interleaved 48-bit pixel words (8 px from each half) into the panel FIFO.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   frame_start, fb_base        frame request and buffer base word address
//   mem_rd, mem_addr            read request / word address
//   mem_ready                   memory accepts the request this cycle
//   mem_rvalid, mem_rdata       read return (pixel0 in [23:21])
//   fifo_we, fifo_wdata         FIFO write strobe / interleaved data
//   fifo_full                   FIFO back-pressure
//   vsync_out, busy, frame_done frame status to the panel controller
module fb_scanner #(
    parameter int WORDS_PER_LINE = 80,
    parameter int HALF_LINES     = 240,
    parameter int LOWER_OFFSET   = 19200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [15:0] fb_base,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [23:0] mem_rdata,
    output logic        fifo_we,
    output logic [47:0] fifo_wdata,
    input  logic        fifo_full,
    output logic        vsync_out,
    output logic        busy,
    output logic        frame_done
);

    localparam int WW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LW = (HALF_LINES > 1) ? $clog2(HALF_LINES) : 1;
    localparam logic [15:0]   LINE_STEP  = 16'(WORDS_PER_LINE);
    localparam logic [15:0]   LOWER_STEP = 16'(LOWER_OFFSET);
    localparam logic [WW-1:0] WORD_LAST  = WW'(WORDS_PER_LINE - 1);
    localparam logic [LW-1:0] LINE_LAST  = LW'(HALF_LINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ_U,
        WAIT_U,
        REQ_L,
        WAIT_L,
        PUSH
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [15:0]     row_addr;
    logic [WW-1:0]   word;
    logic [LW-1:0]   line;
    logic [23:0]     upper;
    logic            accept;
    logic            frame_end;

    // Pixel k of each half lands side by side: upper RGB then lower RGB.
    function automatic logic [47:0] interleave(input logic [23:0] up,
                                               input logic [23:0] lo);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[47-6*k -: 3] = up[23-3*k -: 3];
            r[44-6*k -: 3] = lo[23-3*k -: 3];
        end
        return r;
    endfunction

    // A request coinciding with frame_done is dropped; the next IDLE cycle
    // is the first one that can start a new frame.
    assign accept    = (state == IDLE) && frame_start && !frame_done;
    assign frame_end = fifo_we && (word == WORD_LAST) && (line == LINE_LAST);

    always_comb begin
        state_d  = state;
        mem_rd   = 1'b0;
        mem_addr = '0;
        fifo_we  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_d = REQ_U;
            end
            REQ_U: begin
                mem_rd   = 1'b1;
                mem_addr = row_addr + 16'(word);
                if (mem_ready) state_d = WAIT_U;
            end
            WAIT_U: begin
                if (mem_rvalid) state_d = REQ_L;
            end
            REQ_L: begin
                mem_rd   = 1'b1;
                mem_addr = row_addr + LOWER_STEP + 16'(word);
                if (mem_ready) state_d = WAIT_L;
            end
            WAIT_L: begin
                if (mem_rvalid) state_d = PUSH;
            end
            PUSH: begin
                if (!fifo_full) begin
                    fifo_we = 1'b1;
                    state_d = ((word == WORD_LAST) && (line == LINE_LAST))
                              ? IDLE : REQ_U;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_addr   <= '0;
            word       <= '0;
            line       <= '0;
            upper      <= '0;
            fifo_wdata <= '0;
            vsync_out  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vsync_out  <= accept;
            frame_done <= frame_end;
            if (accept)         busy <= 1'b1;
            else if (frame_end) busy <= 1'b0;

            if (accept) begin
                row_addr <= fb_base;
                word     <= '0;
                line     <= '0;
            end else if (fifo_we) begin
                if (word == WORD_LAST) begin
                    word     <= '0;
                    line     <= line + LW'(1);
                    row_addr <= row_addr + LINE_STEP;
                end else begin
                    word <= word + WW'(1);
                end
            end

            if (state == WAIT_U && mem_rvalid)
                upper <= mem_rdata;
            if (state == WAIT_L && mem_rvalid)
                fifo_wdata <= interleave(upper, mem_rdata);
        end
    end

endmodule

// File: tb/tb_fb_scanner.sv
// tb_fb_scanner: directed bench for fb_scanner with a latency-2 memory
// model returning the address as data, and a FIFO write monitor.
module tb_fb_scanner;

    localparam int WPL = 80;
    localparam int HL  = 3;
    localparam int NW  = WPL * HL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] fb_base = '0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ready = 1'b1;
    logic        mem_rvalid;
    logic [23:0] mem_rdata;
    logic        fifo_we;
    logic [47:0] fifo_wdata;
    logic        fifo_full = 1'b0;
    logic        vsync_out;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    fb_scanner #(
        .WORDS_PER_LINE(WPL),
        .HALF_LINES    (HL),
        .LOWER_OFFSET  (19200)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .fb_base    (fb_base),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .fifo_we    (fifo_we),
        .fifo_wdata (fifo_wdata),
        .fifo_full  (fifo_full),
        .vsync_out  (vsync_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Memory: accepted request returns two cycles later.
    logic        p0 = 1'b0, p1 = 1'b0;
    logic [15:0] a0 = '0, a1 = '0;
    logic        stray = 1'b0;
    logic        ovr = 1'b0;

    always @(posedge clk) begin
        p0 <= mem_rd && mem_ready;
        a0 <= mem_addr;
        p1 <= p0;
        a1 <= a0;
    end

    assign mem_rvalid = p1 | stray;
    assign mem_rdata  = ovr ? ((a1 >= 16'h5B00) ? 24'h053977 : 24'hFAC688)
                            : {8'h00, a1};

    logic [47:0] wq[$];
    logic [15:0] aq[$];
    int vs_cnt = 0;
    int fd_cnt = 0;

    always @(negedge clk) begin
        if (fifo_we) wq.push_back(fifo_wdata);
        if (mem_rd && mem_ready) aq.push_back(mem_addr);
        if (vsync_out) vs_cnt++;
        if (frame_done) fd_cnt++;
    end

    // Expected FIFO word n of a frame: bit-by-bit from the upper/lower
    // word addresses (data = address).
    function automatic logic [47:0] exp_word(input logic [15:0] base,
                                             input int n);
        logic [15:0] ua, la;
        logic [23:0] u, l;
        logic [47:0] r;
        int t, s, k, sb;
        ua = base + 16'((n / WPL) * WPL + (n % WPL));
        la = ua + 16'd19200;
        u = {8'h00, ua};
        l = {8'h00, la};
        for (int b = 0; b < 48; b++) begin
            t  = 47 - b;
            s  = t / 3;
            k  = s / 2;
            sb = 23 - 3 * k - (t % 3);
            r[b] = (s % 2 == 0) ? u[sb] : l[sb];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] b);
        tick();
        fb_base = b;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_fd(input int f0);
        int cyc;
        cyc = 0;
        while (fd_cnt == f0 && cyc < 5000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({mem_rd, fifo_we, vsync_out, busy, frame_done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {mem_rd, fifo_we, vsync_out, busy, frame_done});
        end
        total++;
        if (mem_addr !== 16'h0) begin
            bad++;
            $display("FAIL reset_addr: got %h want 0000", mem_addr);
        end
        total++;
        if (fifo_wdata !== 48'h0) begin
            bad++;
            $display("FAIL reset_wdata: got %h want 0", fifo_wdata);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_frame();
        int v0, f0, nerr;
        wq.delete();
        aq.delete();
        v0 = vs_cnt;
        f0 = fd_cnt;
        start_frame(16'h1000);
        total++;
        if ({vsync_out, busy} !== 2'b11) begin
            bad++;
            $display("FAIL start_vsync_busy: got %b want 11",
                     {vsync_out, busy});
        end
        tick();
        total++;
        if (vsync_out !== 1'b0) begin
            bad++;
            $display("FAIL vsync_width: got %b want 0", vsync_out);
        end
        wait_fd(f0);
        total++;
        if (wq.size() != NW) begin
            bad++;
            $display("FAIL frame_writes: got %0d want %0d", wq.size(), NW);
        end
        total++;
        if (aq.size() < 2 || aq[0] !== 16'h1000 || aq[1] !== 16'h5B00) begin
            bad++;
            $display("FAIL first_reads: got %h %h want 1000 5b00",
                     aq.size() > 0 ? aq[0] : 16'hxxxx,
                     aq.size() > 1 ? aq[1] : 16'hxxxx);
        end
        nerr = 0;
        foreach (wq[i]) if (wq[i] !== exp_word(16'h1000, i)) nerr++;
        total++;
        if (nerr != 0) begin
            bad++;
            $display("FAIL frame_data: got %0d bad words want 0", nerr);
        end
        repeat (5) tick();
        total++;
        if (fd_cnt - f0 != 1 || vs_cnt - v0 != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_pulses: got fd=%0d vs=%0d busy=%b want 1 1 0",
                     fd_cnt - f0, vs_cnt - v0, busy);
        end
    endtask

    task automatic test_pack();
        int f0, cyc;
        logic [47:0] got;
        wq.delete();
        f0 = fd_cnt;
        ovr = 1'b1;
        start_frame(16'h1000);
        cyc = 0;
        while (wq.size() == 0 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        got = (wq.size() > 0) ? wq[0] : 48'hx;
        total++;
        if (got !== 48'hE31AA3715387) begin
            bad++;
            $display("FAIL pack: got %h want e31aa3715387", got);
        end
        wait_fd(f0);
        ovr = 1'b0;
    endtask

    task automatic test_stall();
        int f0, cyc, we_n, rd_n, chg;
        logic [47:0] held;
        wq.delete();
        f0 = fd_cnt;
        start_frame(16'h1000);
        cyc = 0;
        while (wq.size() < 5 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        tick();
        fifo_full = 1'b1;
        we_n = 0;
        rd_n = 0;
        chg  = 0;
        held = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fifo_we) we_n++;
            if (i == 12) held = fifo_wdata;
            if (i >= 12) begin
                if (mem_rd) rd_n++;
                if (fifo_wdata !== held) chg++;
            end
        end
        total++;
        if (we_n != 0 || wq.size() != 5) begin
            bad++;
            $display("FAIL stall_we: got we=%0d writes=%0d want 0 5",
                     we_n, wq.size());
        end
        total++;
        if (rd_n != 0 || chg != 0) begin
            bad++;
            $display("FAIL stall_hold: got rd=%0d chg=%0d want 0 0",
                     rd_n, chg);
        end
        tick();
        fifo_full = 1'b0;
        #1;
        total++;
        if (fifo_we !== 1'b1 || fifo_wdata !== exp_word(16'h1000, 5)) begin
            bad++;
            $display("FAIL stall_release: got we=%b %h want 1 %h",
                     fifo_we, fifo_wdata, exp_word(16'h1000, 5));
        end
        wait_fd(f0);
        total++;
        if (wq.size() != NW) begin
            bad++;
            $display("FAIL stall_writes: got %0d want %0d", wq.size(), NW);
        end
    endtask

    task automatic test_wrap();
        int f0, nerr;
        wq.delete();
        aq.delete();
        f0 = fd_cnt;
        start_frame(16'hFFF0);
        wait_fd(f0);
        total++;
        if (aq.size() < 161 || aq[0] !== 16'hFFF0 || aq[1] !== 16'h4AF0 ||
            aq[160] !== 16'h0040) begin
            bad++;
            $display("FAIL wrap_addr: got %h %h %h want fff0 4af0 0040",
                     aq.size() > 0 ? aq[0] : 16'hxxxx,
                     aq.size() > 1 ? aq[1] : 16'hxxxx,
                     aq.size() > 160 ? aq[160] : 16'hxxxx);
        end
        nerr = 0;
        foreach (wq[i]) if (wq[i] !== exp_word(16'hFFF0, i)) nerr++;
        total++;
        if (nerr != 0 || wq.size() != NW) begin
            bad++;
            $display("FAIL wrap_data: got %0d bad of %0d want 0 of %0d",
                     nerr, wq.size(), NW);
        end
    endtask

    task automatic test_back_to_back();
        int v0, f0, cyc, nerr, a_new;
        wq.delete();
        aq.delete();
        v0 = vs_cnt;
        f0 = fd_cnt;
        start_frame(16'h1000);
        repeat (200) tick();
        fb_base = 16'h3000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        cyc = 0;
        while (!(fifo_we && wq.size() == NW) && cyc < 5000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        nerr = 0;
        foreach (wq[i]) if (wq[i] !== exp_word(16'h1000, i)) nerr++;
        total++;
        if (nerr != 0 || wq.size() != NW || vs_cnt - v0 != 1) begin
            bad++;
            $display("FAIL midframe_ignore: got bad=%0d n=%0d vs=%0d want 0 %0d 1",
                     nerr, wq.size(), vs_cnt - v0, NW);
        end
        a_new = aq.size();
        tick();
        frame_start = 1'b1;
        total++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_cycle: got fd=%b busy=%b want 1 0",
                     frame_done, busy);
        end
        tick();
        total++;
        if (vsync_out !== 1'b0) begin
            bad++;
            $display("FAIL done_start_ignored: got vsync=%b want 0", vsync_out);
        end
        tick();
        frame_start = 1'b0;
        total++;
        if ({vsync_out, busy} !== 2'b11) begin
            bad++;
            $display("FAIL restart: got %b want 11", {vsync_out, busy});
        end
        wait_fd(f0 + 1);
        total++;
        if (aq.size() <= a_new || aq[a_new] !== 16'h3000 ||
            vs_cnt - v0 != 2 || fd_cnt - f0 != 2) begin
            bad++;
            $display("FAIL restart_frame: got addr=%h vs=%0d fd=%0d want 3000 2 2",
                     aq.size() > a_new ? aq[a_new] : 16'hxxxx,
                     vs_cnt - v0, fd_cnt - f0);
        end
    endtask

    task automatic test_reset_mid();
        int f0, cyc, we_n, busy_n, rd_n;
        aq.delete();
        start_frame(16'h1000);
        cyc = 0;
        while (aq.size() < 2 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_rd, fifo_we, vsync_out, busy, frame_done} !== 5'b0 ||
            mem_addr !== 16'h0 || fifo_wdata !== 48'h0) begin
            bad++;
            $display("FAIL midreset_out: got %b %h %h want 00000 0 0",
                     {mem_rd, fifo_we, vsync_out, busy, frame_done},
                     mem_addr, fifo_wdata);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        wq.delete();
        tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        we_n = 0;
        busy_n = 0;
        rd_n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifo_we) we_n++;
            if (busy) busy_n++;
            if (mem_rd) rd_n++;
        end
        total++;
        if (we_n != 0 || busy_n != 0 || rd_n != 0 || wq.size() != 0) begin
            bad++;
            $display("FAIL midreset_idle: got we=%0d busy=%0d rd=%0d want 0 0 0",
                     we_n, busy_n, rd_n);
        end
        f0 = fd_cnt;
        start_frame(16'h2000);
        total++;
        if (vsync_out !== 1'b1) begin
            bad++;
            $display("FAIL midreset_restart: got vsync=%b want 1", vsync_out);
        end
        wait_fd(f0);
        total++;
        if (wq.size() != NW || wq[0] !== exp_word(16'h2000, 0)) begin
            bad++;
            $display("FAIL midreset_frame: got n=%0d w0=%h want %0d %h",
                     wq.size(), wq.size() > 0 ? wq[0] : 48'hx,
                     NW, exp_word(16'h2000, 0));
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_pack();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
